// File: rtl/ped_request.sv
// rtl/ped_request.sv - pedestrian pushbutton synchroniser/debouncer with latched request and tick-timed lockout
// Optional press queuing during lockout is enabled by defining PED_REQ_QUEUE_EN.
module ped_request #(
    parameter int CLK_HZ      = 12000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LOCKOUT_S   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       tick_1s,
    input  logic       ack,
    output logic       req,
    output logic       lockout,
    output logic [7:0] req_cnt
);

    localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [7:0]      LOCK_LOAD = 8'(LOCKOUT_S);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            lockout_q, lockout_d;
    logic [7:0]      req_cnt_q, req_cnt_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d;
`ifdef PED_REQ_QUEUE_EN
    logic            queued_q, queued_d;
`endif

    // Debounce: count only while the synchronised level disagrees with db.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d    = sync2_q;
                press_d = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        lockout_d  = lockout_q;
        req_cnt_d  = req_cnt_q;
        lock_cnt_d = lock_cnt_q;
`ifdef PED_REQ_QUEUE_EN
        queued_d   = queued_q;
`endif
        case (state_q)
            IDLE: begin
                req_d     = 1'b0;
                lockout_d = 1'b0;
                if (press_q) begin
                    state_d   = PENDING;
                    req_d     = 1'b1;
                    req_cnt_d = req_cnt_q + 8'd1;
                end
            end
            PENDING: begin
                req_d     = 1'b1;
                lockout_d = 1'b0;
                if (ack) begin
                    state_d    = LOCKOUT;
                    req_d      = 1'b0;
                    lockout_d  = 1'b1;
                    lock_cnt_d = LOCK_LOAD;
`ifdef PED_REQ_QUEUE_EN
                    if (press_q) begin
                        queued_d = 1'b1;
                    end
`endif
                end
            end
            LOCKOUT: begin
                req_d     = 1'b0;
                lockout_d = 1'b1;
`ifdef PED_REQ_QUEUE_EN
                if (press_q) begin
                    queued_d = 1'b1;
                end
`endif
                if (tick_1s) begin
                    // A zero count is unreachable but is treated as expiry so the FSM cannot stick.
                    if (lock_cnt_q <= 8'd1) begin
                        lock_cnt_d = 8'd0;
                        lockout_d  = 1'b0;
                        state_d    = IDLE;
`ifdef PED_REQ_QUEUE_EN
                        if (queued_q || press_q) begin
                            state_d   = PENDING;
                            req_d     = 1'b1;
                            req_cnt_d = req_cnt_q + 8'd1;
                            queued_d  = 1'b0;
                        end
`endif
                    end else begin
                        lock_cnt_d = lock_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                req_d      = 1'b0;
                lockout_d  = 1'b0;
                lock_cnt_d = 8'd0;
`ifdef PED_REQ_QUEUE_EN
                queued_d   = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_q       <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            state_q    <= IDLE;
            req_q      <= 1'b0;
            lockout_q  <= 1'b0;
            req_cnt_q  <= 8'd0;
            lock_cnt_q <= 8'd0;
        end else begin
            sync1_q    <= btn_n;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            state_q    <= state_d;
            req_q      <= req_d;
            lockout_q  <= lockout_d;
            req_cnt_q  <= req_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

`ifdef PED_REQ_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queued_q <= 1'b0;
        end else begin
            queued_q <= queued_d;
        end
    end
`endif

    assign req     = req_q;
    assign lockout = lockout_q;
    assign req_cnt = req_cnt_q;

endmodule

// File: tb/tb_ped_request.sv
// tb/tb_ped_request.sv - directed scoreboard bench for ped_request (DB_CYCLES=4, LOCKOUT_S=3)
module tb_ped_request;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b1;
    logic       tick_1s = 1'b0;
    logic       ack = 1'b0;
    logic       req;
    logic       lockout;
    logic [7:0] req_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int req_rises = 0;
    int rises0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    ped_request #(
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(4),
        .LOCKOUT_S  (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n  (btn_n),
        .tick_1s(tick_1s),
        .ack    (ack),
        .req    (req),
        .lockout(lockout),
        .req_cnt(req_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge req) req_rises++;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: observed %0d expected <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_bad++;
                $display("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
                $error("check %s observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_pulse();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        // Reset held with button pressed
        btn_n = 1'b0;
        push("rst_req", 0); push("rst_lockout", 0); push("rst_cnt", 0);
        step(3);
        pop_check({31'b0, req}); pop_check({31'b0, lockout}); pop_check({24'b0, req_cnt});

        // Release: first edge after release is edge 0, req rises on edge 6
        rst_n = 1'b1;
        push("rel_req_edge5", 0);
        step(6);
        pop_check({31'b0, req});
        push("rel_req_edge6", 1); push("rel_cnt", 1);
        step(1);
        pop_check({31'b0, req}); pop_check({24'b0, req_cnt});

        // Handshake
        btn_n = 1'b1;
        step(10);
        push("hs_req_held", 1);
        pop_check({31'b0, req});
        ack = 1'b1;
        push("hs_req_fall", 0); push("hs_lockout_rise", 1);
        step(1);
        ack = 1'b0;
        pop_check({31'b0, req}); pop_check({31'b0, lockout});
        for (int i = 1; i <= 3; i++) begin
            push($sformatf("hs_lockout_tick%0d", i), (i < 3) ? 1 : 0);
            tick_pulse();
            pop_check({31'b0, lockout});
            step(2);
        end
        push("hs_cnt", 1);
        pop_check({24'b0, req_cnt});

        // Bounce from fresh reset
        do_reset();
        rises0 = req_rises;
        repeat (5) begin
            btn_n = 1'b0; step(3);
            btn_n = 1'b1; step(1);
        end
        push("bounce_no_req", 0);
        pop_check({31'b0, req});
        btn_n = 1'b0;
        push("bounce_rises", 1); push("bounce_req", 1); push("bounce_cnt", 1);
        step(10);
        pop_check(32'(req_rises - rises0)); pop_check({31'b0, req}); pop_check({24'b0, req_cnt});

        // ack coincident with tick: load wins, three more ticks needed
        btn_n = 1'b1;
        step(8);
        ack = 1'b1; tick_1s = 1'b1;
        push("sim_req", 0); push("sim_lockout", 1);
        step(1);
        ack = 1'b0; tick_1s = 1'b0;
        pop_check({31'b0, req}); pop_check({31'b0, lockout});
        for (int i = 1; i <= 3; i++) begin
            push($sformatf("sim_lockout_tick%0d", i), (i < 3) ? 1 : 0);
            step(1);
            tick_pulse();
            pop_check({31'b0, lockout});
        end

        // Press during lockout
        btn_n = 1'b0; step(8);
        btn_n = 1'b1; step(8);
        push("lp_cnt_before", 2);
        pop_check({24'b0, req_cnt});
        ack = 1'b1;
        push("lp_lockout", 1);
        step(1);
        ack = 1'b0;
        pop_check({31'b0, lockout});
        btn_n = 1'b0; step(8);
        btn_n = 1'b1; step(8);
        push("lp_req_in_lockout", 0);
        pop_check({31'b0, req});
        tick_pulse(); step(1);
        tick_pulse(); step(1);
        push("lp_req_tick2", 0); push("lp_lockout_tick2", 1);
        pop_check({31'b0, req}); pop_check({31'b0, lockout});
`ifdef PED_REQ_QUEUE_EN
        push("lp_lockout_end", 0); push("lp_req_queued", 1); push("lp_cnt_after", 3);
`else
        push("lp_lockout_end", 0); push("lp_req_dropped", 0); push("lp_cnt_after", 2);
`endif
        tick_pulse();
        pop_check({31'b0, lockout}); pop_check({31'b0, req}); pop_check({24'b0, req_cnt});

        // Wrap after 256 full cycles
        do_reset();
        for (int i = 0; i < 256; i++) begin
            btn_n = 1'b0; step(7);
            btn_n = 1'b1; step(7);
            if (i == 254) begin
                push("wrap_cnt_255", 255);
                pop_check({24'b0, req_cnt});
            end
            ack = 1'b1; step(1); ack = 1'b0;
            repeat (3) tick_pulse();
        end
        push("wrap_cnt_0", 0); push("wrap_lockout", 0); push("wrap_req", 0);
        step(1);
        pop_check({24'b0, req_cnt}); pop_check({31'b0, lockout}); pop_check({31'b0, req});

        // Asynchronous reset while PENDING
        btn_n = 1'b0;
        push("ar_req_pending", 1);
        step(8);
        pop_check({31'b0, req});
        btn_n = 1'b1;
        #2;
        rst_n = 1'b0;
        push("ar_req_async", 0); push("ar_cnt_async", 0);
        #1;
        pop_check({31'b0, req}); pop_check({24'b0, req_cnt});
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ped_request.md
# ped_request

Pedestrian-request conditioner sitting directly upstream of the traffic-light controller's pedestrian input. It synchronises and debounces the raw active-low pushbutton and latches a clean request level, `req`. `req` is held until the controller acknowledges that the pedestrian phase has started. After the acknowledge, a lockout measured in 1 s ticks from the clock divider must expire before another request is accepted.

## Interface
- `CLK_HZ`, 12000000, input clock frequency in Hz.
- `DEBOUNCE_MS`, 20, stable time required before a button level change is accepted.
  - DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
  - Must be ≥ 2.
- `LOCKOUT_S`, 10, number of `tick_1s` pulses after `ack` during which new presses are not accepted; 1..255.

Ports:
- `clk` in 1: system clock, 12 MHz.
- `rst_n` in 1: reset; one clock; asynchronous, active-low.
- `btn_n` in 1: raw pushbutton, asynchronous, low = pressed.
- `tick_1s` in 1: one-cycle pulse per second from the clock divider, synchronous to `clk`.
- `ack` in 1: one-cycle pulse from the controller when the pedestrian phase begins.
- `req` out 1: registered request level to the controller.
- `lockout` out 1: high while in LOCKOUT.
- `req_cnt` out 8: count of accepted requests, wraps 255→0.

## Operation
Input conditioning:
- Two-flop synchroniser on `btn_n`, reset value 1.
- Debounce:
  - Counter, width $clog2(DB_CYCLES), runs while the synchronised level differs from the debounced level `db`.
  - The counter clears whenever the two levels agree.
  - When the counter reaches DB_CYCLES-1 while still differing, `db` takes the new level and the counter clears.
  - `db` reset value is 1 (released).
- `press` is a one-cycle internal pulse on a debounced 1→0 transition only. Release generates nothing.

State machine (reset state IDLE):
- IDLE: on `press`, go to PENDING, set `req`=1, increment `req_cnt`. `ack` is ignored.
- PENDING:
  - `req` is held at 1.
  - On `ack`: `req`=0, load lockout counter with LOCKOUT_S, go to LOCKOUT.
  - Further presses are ignored and `req_cnt` is unchanged.
  - `press` and `ack` in the same cycle: `ack` is processed; the press is handled as in LOCKOUT (see Configuration).
- LOCKOUT:
  - `lockout`=1.
  - Each `tick_1s` decrements the 8-bit counter.
  - A tick with the counter at 1 ends the lockout: go to IDLE, or to PENDING if a request is queued (see Configuration).
  - `ack` is ignored.
- Illegal state encodings return to IDLE.

Reset values:
- `req`=0, `lockout`=0, `req_cnt`=0.
- Synchroniser flops and `db` = 1.
- Debounce and lockout counters = 0.

Reset mid-operation: all state is cleared immediately and asynchronously; any pending request is lost.

## Timing
- `btn_n` falling and stable before clock edge N:
  - `db` falls at edge N+1+DB_CYCLES.
  - `req` rises at edge N+2+DB_CYCLES.
- Glitches shorter than DB_CYCLES cycles (after synchronisation) produce no `press`.
- `req` falls on the edge that samples `ack`=1; `lockout` rises on the same edge.
- `tick_1s` coinciding with `ack`: the load wins and the tick is not counted.
- Lockout lasts exactly LOCKOUT_S accepted ticks. `lockout` falls on the edge sampling the LOCKOUT_S-th tick.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Configuration
Macro `PED_REQ_QUEUE_EN`.
- Defined:
  - A `press` in LOCKOUT, or simultaneous with `ack` in PENDING, sets a one-bit `queued` flag.
  - At lockout expiry with `queued`=1, go directly to PENDING (`req`=1 on the same edge `lockout` falls), increment `req_cnt`, and clear `queued`.
  - `queued` resets to 0.
- Undefined:
  - Presses in LOCKOUT are discarded.
  - Expiry always goes to IDLE.
  - No `queued` flop exists.

## Test plan
Use CLK_HZ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4), LOCKOUT_S=3.
- Reset: hold `rst_n`=0 with `btn_n`=0 → `req`=0, `lockout`=0, `req_cnt`=0. Release reset with `btn_n` held low → `req`=1 at edge 6 after release, `req_cnt`=1.
- Bounce: `btn_n` low 3 cycles, high 1 cycle, repeated 5 times, then low 10 cycles → exactly one `req` rise, `req_cnt`=1.
- Handshake: press, then `ack` pulse → `req` falls and `lockout` rises on that edge. Three `tick_1s` pulses → `lockout`=0 after the third; ticks 1 and 2 leave it high.
- Simultaneous events, `ack` with `tick_1s` in the same cycle → lockout still needs 3 further ticks.
  - Without the macro, a press during lockout → no `req`, `req_cnt` unchanged.
- With `PED_REQ_QUEUE_EN`: press during lockout → `req`=1 on the edge `lockout` falls, `req_cnt` increments by 1.
- Wrap: 256 full press/ack/lockout cycles → `req_cnt` returns to 0. Assert `rst_n`=0 in PENDING → `req` drops asynchronously, without waiting for a clock edge.
